ultrasonic_ranger: RTL

//  HC-SR04 ranging front end. Issues trigger pulses, times the echo pulse and converts it to

---
 rtl/ultrasonic_pkg.sv | 25 ++
 rtl/ultrasonic_ranger_median3.sv | 20 ++
 rtl/ultrasonic_ranger.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the HC-SR04 ranging front end: FSM states and distance constants.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_HI,
    S_MEASURE,
    S_DONE_OK,
    S_DONE_TO,
    S_HOLDOFF
  } state_e;

  localparam int unsigned US_PER_CM    = 58;
  localparam logic [15:0] DIST_TIMEOUT = 16'hFFFF;
  localparam logic [15:0] DIST_MAX     = 16'hFFFE;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_median3.sv
// Three-input 16-bit median, pure combinational compare network.
module median3 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  output logic [15:0] med
);

  logic [15:0] lo_ab;
  logic [15:0] hi_ab;
  logic [15:0] lo_hc;

  always_comb begin
    lo_ab = (a < b) ? a : b;
    hi_ab = (a < b) ? b : a;
    lo_hc = (hi_ab < c) ? hi_ab : c;
    med   = (lo_ab > lo_hc) ? lo_ab : lo_hc;
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranging front end: trigger, echo timing, incremental us->cm conversion.
// Optional median-of-3 output filter enabled by defining ULTRASONIC_MEDIAN_FILTER_EN.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned TRIG_US     = 10,
  parameter int unsigned TIMEOUT_US  = 30_000,
  parameter int unsigned HOLDOFF_US  = 30_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned PRESCALE = CLK_FREQ_HZ / 1_000_000;
  localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned US_MAX   = max3(TRIG_US, TIMEOUT_US, HOLDOFF_US);
  localparam int unsigned US_W     = $clog2(US_MAX + 1);

  state_e            state_q, state_d;
  logic [PS_W-1:0]   ps_q;
  logic              us_tick;
  logic              echo_meta_q, echo_s_q, echo_prev_q;
  logic              echo_rise, echo_fall;
  logic [US_W-1:0]   us_q, us_d;
  logic [15:0]       cm_q, cm_d;
  logic [5:0]        sub_q, sub_d;
  logic              done_ok, done_to;
  logic              raw_valid;
  logic [15:0]       raw_dist;
  logic [15:0]       dist_q;
  logic              valid_q, timeout_q;

  assign us_tick   = (ps_q == PS_W'(PRESCALE - 1));
  assign echo_rise = echo_s_q & ~echo_prev_q;
  assign echo_fall = ~echo_s_q & echo_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q        <= '0;
      echo_meta_q <= 1'b0;
      echo_s_q    <= 1'b0;
      echo_prev_q <= 1'b0;
      state_q     <= S_IDLE;
      us_q        <= '0;
      cm_q        <= '0;
      sub_q       <= '0;
    end else begin
      ps_q        <= us_tick ? '0 : ps_q + PS_W'(1);
      echo_meta_q <= echo;
      echo_s_q    <= echo_meta_q;
      echo_prev_q <= echo_s_q;
      state_q     <= state_d;
      us_q        <= us_d;
      cm_q        <= cm_d;
      sub_q       <= sub_d;
    end
  end

  // An echo edge wins over a coincident us_tick, so that tick is never counted.
  always_comb begin
    state_d = state_q;
    us_d    = us_q;
    cm_d    = cm_q;
    sub_d   = sub_q;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        us_d  = '0;
        cm_d  = '0;
        sub_d = '0;
        if (enable) state_d = S_TRIG;
      end
      S_TRIG: begin
        if (us_tick) begin
          if (us_q == US_W'(TRIG_US - 1)) begin
            state_d = S_WAIT_HI;
            us_d    = '0;
          end else begin
            us_d = us_q + US_W'(1);
          end
        end
      end
      S_WAIT_HI: begin
        if (echo_rise) begin
          state_d = S_MEASURE;
          us_d    = '0;
        end else if (us_tick) begin
          if (us_q == US_W'(TIMEOUT_US - 1)) state_d = S_DONE_TO;
          else                               us_d    = us_q + US_W'(1);
        end
      end
      S_MEASURE: begin
        if (echo_fall) begin
          state_d = S_DONE_OK;
        end else if (us_tick) begin
          if (us_q == US_W'(TIMEOUT_US - 1)) begin
            state_d = S_DONE_TO;
          end else begin
            us_d = us_q + US_W'(1);
            if (sub_q == 6'(US_PER_CM - 1)) begin
              sub_d = '0;
              cm_d  = (cm_q == DIST_MAX) ? cm_q : cm_q + 16'd1;
            end else begin
              sub_d = sub_q + 6'd1;
            end
          end
        end
      end
      S_DONE_OK: begin
        done_ok = 1'b1;
        us_d    = '0;
        state_d = S_HOLDOFF;
      end
      S_DONE_TO: begin
        done_to = 1'b1;
        us_d    = '0;
        state_d = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        if (us_tick) begin
          if (us_q == US_W'(HOLDOFF_US - 1)) state_d = S_IDLE;
          else                               us_d    = us_q + US_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign raw_valid = done_ok | done_to;
  assign raw_dist  = done_to ? DIST_TIMEOUT : cm_q;

`ifdef ULTRASONIC_MEDIAN_FILTER_EN
  logic [15:0] hist0_q, hist1_q, hist2_q;
  logic        valid_p_q, to_p_q;
  logic [15:0] med;

  median3 u_median3 (
    .a   (hist0_q),
    .b   (hist1_q),
    .c   (hist2_q),
    .med (med)
  );

  // History shifts on the DONE cycle; the median is registered one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist0_q   <= DIST_TIMEOUT;
      hist1_q   <= DIST_TIMEOUT;
      hist2_q   <= DIST_TIMEOUT;
      valid_p_q <= 1'b0;
      to_p_q    <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      dist_q    <= DIST_TIMEOUT;
    end else begin
      if (raw_valid) begin
        hist0_q <= raw_dist;
        hist1_q <= hist0_q;
        hist2_q <= hist1_q;
      end
      valid_p_q <= raw_valid;
      to_p_q    <= done_to;
      valid_q   <= valid_p_q;
      timeout_q <= to_p_q;
      if (valid_p_q) dist_q <= med;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      dist_q    <= DIST_TIMEOUT;
    end else begin
      valid_q   <= raw_valid;
      timeout_q <= done_to;
      if (raw_valid) dist_q <= raw_dist;
    end
  end
`endif

  assign trig     = (state_q == S_TRIG);
  assign busy     = (state_q != S_IDLE);
  assign distance = dist_q;
  assign valid    = valid_q;
  assign timeout  = timeout_q;

endmodule
